// File: rtl/vga_pkg.sv
// Purpose: shared 640x480@60 raster constants, cell-grid geometry and pixel type.
// Latency: n/a (definitions only).
// Backpressure: n/a; the raster free-runs.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int CELL_SIZE = 16;
  localparam int FB_COLS   = 40;
  localparam int FB_ROWS   = 30;
  localparam int FB_BITS   = FB_COLS * FB_ROWS;

  localparam int CNT_W = 10;
  localparam int IDX_W = 11;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Row-major bit index of a 16x16 cell; callers pass the counter bits above the cell size.
  function automatic logic [IDX_W-1:0] cell_index(input logic [5:0] col, input logic [4:0] row);
    logic [IDX_W-1:0] r_ext;
    logic [IDX_W-1:0] c_ext;
    r_ext = IDX_W'(row);
    c_ext = IDX_W'(col);
    return r_ext * IDX_W'(FB_COLS) + c_ext;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Purpose: horizontal/vertical raster counters with raw visible and active-low sync decode.
// Latency: decode is combinational from the counters; counters advance every cycle.
// Backpressure: none; free-running.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             visible,
  output logic             hsync_raw,
  output logic             vsync_raw
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VIS + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VIS + H_FRONT + H_PULSE - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VIS + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VIS + V_FRONT + V_PULSE - 1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

endmodule

// File: rtl/framebuffer_scan.sv
// Purpose: scans a snapshotted 40x30 cell bitmap onto a 640x480 VGA raster.
// Latency: 1 cycle from counter state to registered sync/colour; no backpressure, free-running.
module framebuffer_scan
  import vga_pkg::*;
#(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int H_VIS   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_VIS   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FB_BITS-1:0] framebuffer,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vblank_start
);

  localparam logic [CNT_W-1:0] SNAP_ROW = CNT_W'(V_VIS);

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               visible;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               snap_point;
  logic [IDX_W-1:0]   cell_idx;
  logic [FB_BITS-1:0] shadow;
  rgb_t               pixel_d;
  rgb_t               pixel_q;

  vga_timing #(
    .H_VIS   (H_VIS),
    .H_FRONT (H_FRONT),
    .H_PULSE (H_PULSE),
    .H_BACK  (H_BACK),
    .V_VIS   (V_VIS),
    .V_FRONT (V_FRONT),
    .V_PULSE (V_PULSE),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clock     (clock),
    .reset_n   (reset_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  // First blanking line: the whole visible frame has been drawn from the old shadow.
  assign snap_point = (h_cnt == '0) && (v_cnt == SNAP_ROW);
  assign cell_idx   = visible ? cell_index(h_cnt[9:4], v_cnt[8:4]) : '0;

  always_comb begin
    pixel_d = '0;
    if (visible) begin
      pixel_d = shadow[cell_idx] ? rgb_t'(FG_COLOR) : rgb_t'(BG_COLOR);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow       <= '0;
      vga_hsync    <= 1'b1;
      vga_vsync    <= 1'b1;
      pixel_q      <= '0;
      vblank_start <= 1'b0;
    end else begin
      if (snap_point) begin
        shadow <= framebuffer;
      end
      vblank_start <= snap_point;
      vga_hsync    <= hsync_raw;
      vga_vsync    <= vsync_raw;
      pixel_q      <= pixel_d;
    end
  end

  assign vga_r = pixel_q.r;
  assign vga_g = pixel_q.g;
  assign vga_b = pixel_q.b;

endmodule

// File: tb/tb_framebuffer_scan.sv
// Directed bench: a full-size instance for reset and line timing, and a reduced-raster
// instance (4x2 visible cells, 80x40 raster) for snapshot, colour and tearing behaviour.
module tb_framebuffer_scan;

  localparam int HT    = 80;
  localparam int FRAME = 3200;
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h123;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1199:0] framebuffer;

  logic       hs, vs, vb;
  logic [3:0] r, g, b;
  logic       f_hs, f_vs, f_vb;
  logic [3:0] f_r, f_g, f_b;

  int k;
  int n_checks;
  int n_fail;
  int pulses;
  logic [1199:0] exp_sh;

  always #20 clock = ~clock;

  framebuffer_scan #(
    .FG_COLOR (FG),
    .BG_COLOR (BG),
    .H_VIS    (64),
    .H_FRONT  (4),
    .H_PULSE  (8),
    .H_BACK   (4),
    .V_VIS    (32),
    .V_FRONT  (2),
    .V_PULSE  (2),
    .V_BACK   (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .framebuffer  (framebuffer),
    .vga_hsync    (hs),
    .vga_vsync    (vs),
    .vga_r        (r),
    .vga_g        (g),
    .vga_b        (b),
    .vblank_start (vb)
  );

  framebuffer_scan dut_full (
    .clock        (clock),
    .reset_n      (reset_n),
    .framebuffer  (framebuffer),
    .vga_hsync    (f_hs),
    .vga_vsync    (f_vs),
    .vga_r        (f_r),
    .vga_g        (f_g),
    .vga_b        (f_b),
    .vblank_start (f_vb)
  );

  // Expected outputs after the k-th edge since reset release (they describe counter state k-1).
  function automatic logic [11:0] exp_rgb(input int kk, input logic [1199:0] sh);
    int c, h, v;
    c = (kk - 1) % FRAME;
    h = c % HT;
    v = c / HT;
    if (h < 64 && v < 32) return sh[(v / 16) * 40 + h / 16] ? FG : BG;
    return 12'h000;
  endfunction

  function automatic logic exp_hs(input int kk);
    int h;
    h = (kk - 1) % HT;
    return !(h >= 68 && h <= 75);
  endfunction

  function automatic logic exp_vs(input int kk);
    int v;
    v = ((kk - 1) % FRAME) / HT;
    return !(v == 34 || v == 35);
  endfunction

  function automatic logic exp_vb(input int kk);
    return ((kk - 1) % FRAME) == 2560;
  endfunction

  function automatic logic [1199:0] one_bit(input int idx);
    logic [1199:0] t;
    t = '0;
    t[idx] = 1'b1;
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    k++;
    if (vb === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    framebuffer = {40{30'h2AAA_5555}};
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({hs, vs, vb} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_ctl got hs/vs/vb=%b required 110", {hs, vs, vb});
    end
    n_checks++;
    if ({r, g, b} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_rgb got %h required 000", {r, g, b});
    end
    n_checks++;
    if ({f_hs, f_vs, f_vb, f_r, f_g, f_b} !== 15'b110_0000_0000_0000) begin
      n_fail++;
      $display("FAIL reset_full got %b required 110 + rgb 0", {f_hs, f_vs, f_vb, f_r, f_g, f_b});
    end
    reset_n = 1'b1;
    k = 0;
    pulses = 0;
  endtask

  // First frame: empty shadow, sync timing on both instances, full-size hsync period/width.
  task automatic test_blank_frame();
    int falls[$];
    int low_cnt;
    logic prev_fhs;
    int h;
    framebuffer = one_bit(0);
    exp_sh = '0;
    low_cnt = 0;
    prev_fhs = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL blank_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
      n_checks++;
      if ({hs, vs, vb} !== {exp_hs(k), exp_vs(k), exp_vb(k)}) begin
        n_fail++;
        $display("FAIL blank_sync k=%0d got %b required %b", k, {hs, vs, vb},
                 {exp_hs(k), exp_vs(k), exp_vb(k)});
      end
      h = (k - 1) % 800;
      n_checks++;
      if ({f_hs, f_vs, f_vb} !== {!(h >= 656 && h <= 751), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL full_sync k=%0d got %b required %b", k, {f_hs, f_vs, f_vb},
                 {!(h >= 656 && h <= 751), 1'b1, 1'b0});
      end
      if (f_hs === 1'b0) low_cnt++;
      if (prev_fhs === 1'b1 && f_hs === 1'b0) falls.push_back(k);
      prev_fhs = f_hs;
    end
    n_checks++;
    if (falls.size() != 4 || falls[1] - falls[0] != 800 || falls[3] - falls[2] != 800) begin
      n_fail++;
      $display("FAIL hsync_period got %0d edges first gap %0d required 4 edges gap 800",
               falls.size(), (falls.size() > 1) ? falls[1] - falls[0] : -1);
    end
    n_checks++;
    if (low_cnt != 4 * 96) begin
      n_fail++;
      $display("FAIL hsync_low_width got %0d low cycles required %0d", low_cnt, 4 * 96);
    end
  endtask

  // Frame 1 shows only bit 0; live input changes mid-frame must not show.
  task automatic test_bit0();
    exp_sh = one_bit(0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i == 100) framebuffer = one_bit(43);
      if (i == 2000) framebuffer = one_bit(43) | one_bit(1199);
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL bit0_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
      n_checks++;
      if (vb !== exp_vb(k)) begin
        n_fail++;
        $display("FAIL bit0_vblank k=%0d got %b required %b", k, vb, exp_vb(k));
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL vblank_count got %0d required 2", pulses);
    end
  endtask

  // Frame 2: last visible cell (col 3, row 1); blanking to the right must stay 0.
  task automatic test_last_cell();
    exp_sh = one_bit(43) | one_bit(1199);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i == 1000) framebuffer = '1;
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL last_cell_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
    end
  endtask

  // Frame 3 all-ones with the input cleared mid-frame; frame 4 visible area must be background.
  task automatic test_tear();
    exp_sh = '1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i == 12 * HT + 32) framebuffer = '0;
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL tear_hold_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
    end
    exp_sh = '0;
    for (int i = 0; i < 2560; i++) begin
      tick();
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL tear_next_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
    end
  endtask

  // Bit 41 rises during the very cycle whose closing edge is the snapshot edge.
  task automatic test_snapshot_race();
    framebuffer = one_bit(41);
    tick();
    n_checks++;
    if (vb !== 1'b1) begin
      n_fail++;
      $display("FAIL race_vblank k=%0d got %b required 1", k, vb);
    end
    exp_sh = one_bit(41);
    for (int i = 0; i < FRAME + 639; i++) begin
      tick();
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL race_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
    end
  endtask

  // Reset at (40, 20) mid-frame, then scan restarts from (0, 0) with an empty shadow.
  task automatic test_mid_reset();
    while (k % FRAME != 1640) tick();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if ({hs, vs, vb, r, g, b} !== 15'b110_0000_0000_0000) begin
      n_fail++;
      $display("FAIL midreset_out got %b required 110 + rgb 0", {hs, vs, vb, r, g, b});
    end
    n_checks++;
    if ({f_hs, f_vs, f_vb} !== 3'b110) begin
      n_fail++;
      $display("FAIL midreset_full got %b required 110", {f_hs, f_vs, f_vb});
    end
    reset_n = 1'b1;
    k = 0;
    pulses = 0;
    exp_sh = '0;
    for (int i = 0; i < FRAME + 2560; i++) begin
      tick();
      if (k == 2562) exp_sh = one_bit(41);
      n_checks++;
      if ({r, g, b} !== exp_rgb(k, exp_sh)) begin
        n_fail++;
        $display("FAIL restart_rgb k=%0d got %h required %h", k, {r, g, b}, exp_rgb(k, exp_sh));
      end
      n_checks++;
      if ({hs, vs, vb} !== {exp_hs(k), exp_vs(k), exp_vb(k)}) begin
        n_fail++;
        $display("FAIL restart_sync k=%0d got %b required %b", k, {hs, vs, vb},
                 {exp_hs(k), exp_vs(k), exp_vb(k)});
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL restart_vblank_count got %0d required 1", pulses);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    k = 0;
    pulses = 0;
    reset_n = 1'b0;
    framebuffer = '0;
    exp_sh = '0;
    test_reset();
    test_blank_frame();
    test_bit0();
    test_last_cell();
    test_tear();
    test_snapshot_race();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scan.md
FRAMEBUFFER_SCAN -- requirements
Module: framebuffer_scan

Interface
REQ-001 Parameter FG_COLOR, default 12'hFFF, 4:4:4 RGB driven for a set cell.
REQ-002 Parameter BG_COLOR, default 12'h000, 4:4:4 RGB driven for a clear cell.
REQ-003 clock  input  1  single clock, 25 MHz pixel clock, all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 framebuffer  input  1200  cell bitmap, 40 cols x 30 rows; bit index = row*40 + col; col 0 = left, row 0 = top.
REQ-006 vga_hsync  output  1  horizontal sync, active-low.
REQ-007 vga_vsync  output  1  vertical sync, active-low.
REQ-008 vga_r, vga_g, vga_b  output  4 each  pixel color.
REQ-009 vblank_start  output  1  one-cycle pulse marking the snapshot point.

Function
REQ-010 The block SHALL keep a horizontal counter h_cnt (0..799) and a vertical counter v_cnt (0..524).
- h_cnt +1 per cycle; wraps 799->0.
- v_cnt +1 on each h wrap; wraps 524->0 when h_cnt wraps.
REQ-011 The block SHALL use 640x480@60 timing:
- H: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- V: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-012 The block SHALL map each cell to a 16x16 pixel block: col = h_cnt[9:4], row = v_cnt[8:4].
- Index = row*40 + col, range 0..1199.
- The index is computed only while visible.
REQ-013 The block SHALL hold a 1200-bit shadow copy of framebuffer and scan pixels from the shadow only, never from the live input.
REQ-014 The block SHALL load the shadow from framebuffer on the edge where (h_cnt, v_cnt) = (0, 480).
- This is the first blanking line; there is no tearing within a frame.
REQ-015 vblank_start SHALL be high for exactly the one cycle after the shadow load, i.e. once per 420000 cycles.
REQ-016 All outputs SHALL be registered with a fixed latency of 1 cycle, with sync and color mutually aligned.
- Outputs in cycle t+1 reflect the counter state in cycle t.
REQ-017 The color output SHALL be:
- while visible: FG_COLOR if the shadow bit is 1, else BG_COLOR;
- outside the visible area: 12'h000 regardless of the bitmap or BG_COLOR.
REQ-018 vga_hsync SHALL be low iff h_cnt was in 656..751 in the previous cycle.
REQ-019 vga_vsync SHALL be low iff v_cnt was in 490..491 in the previous cycle.
REQ-020 Changes to framebuffer between snapshots SHALL have no visible effect until the next (0, 480) point.
REQ-021 If framebuffer changes in the same cycle as the snapshot point, the block SHALL capture the value present at that edge.

Reset
REQ-022 While reset_n is low at a rising edge, the block SHALL apply:
- h_cnt = 0, v_cnt = 0;
- shadow all-zero;
- vga_hsync = 1, vga_vsync = 1;
- rgb = 0;
- vblank_start = 0.
REQ-023 Reset asserted mid-frame SHALL abort the scan; no partial snapshot is taken.
REQ-024 After reset_n rises, the scan SHALL restart at (0, 0).
- The first snapshot occurs 480*800 cycles after reset release.
- The first frame displays BG_COLOR in every visible pixel.

Structure
REQ-025 A shared package vga_pkg SHALL hold all timing constants:
- H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL;
- the V_ equivalents;
- CELL_SIZE = 16, FB_COLS = 40, FB_ROWS = 30, FB_BITS = 1200.
REQ-026 Counters and raw sync/visible decode SHALL live in one sub-module, vga_timing.
- Outputs: h_cnt, v_cnt, visible, hsync_raw, vsync_raw.
- framebuffer_scan adds the shadow, the cell lookup and the output registers.

Verification
REQ-027 Reset then run 840000 cycles:
- hsync period = 800 cycles, low width = 96;
- vsync period = 420000 cycles, low width = 1600;
- vblank_start pulses exactly twice.
REQ-028 Bitmap with only bit 0 set, after one snapshot: FG_COLOR exactly when the lagged counters have h_cnt 0..15 and v_cnt 0..15; BG_COLOR elsewhere while visible.
REQ-029 Only bit 1199 set: FG_COLOR only at h_cnt 624..639, v_cnt 464..479; rgb = 0 at h_cnt 640..799 on those lines.
REQ-030 Tear check:
- all-ones loaded at the snapshot;
- framebuffer changed to all-zeros at (320, 200) of the next frame;
- that frame stays FG_COLOR in every visible pixel;
- the following frame is BG_COLOR.
REQ-031 Reset at (400, 300) mid-frame:
- next cycle: hsync = 1, vsync = 1, rgb = 0;
- after release: counters restart at 0, shadow all-zero, BG_COLOR shown until the first vblank_start.
REQ-032 Snapshot race: framebuffer toggles 0->1 on bit 41 exactly on the (0, 480) edge; the next frame shows cell (col 1, row 1) as FG_COLOR.
